// File: rtl/i2s_sample_serializer.sv
// Buffers a mono Avalon-ST sample stream and serializes each sample as a
// 24-bit stereo I2S frame (same sample on both channels) with sticky flags.
module i2s_sample_serializer #(
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  asi_ss0_data,
  input  logic                         asi_ss0_valid,
  input  logic                         i_clear_flags,
  output logic                         o_bclk,
  output logic                         o_lrclk,
  output logic                         o_sdata,
  output logic                         o_overflow,
  output logic                         o_underflow,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          bclk_q, bclk_d;
  logic          lrclk_q, lrclk_d;
  logic          sdata_q, sdata_d;
  logic [5:0]    slot_q, slot_d, slot_nxt;
  logic [23:0]   shift_q, shift_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic wrap, fall, frame_start, empty, full, pop, push;
  logic unused_hi_bits;

  assign unused_hi_bits = ^asi_ss0_data[31:24];

  assign wrap        = (div_cnt_q == DIV_LAST);
  assign fall        = wrap & bclk_q;
  assign slot_nxt    = slot_q + 6'd1;
  assign frame_start = fall & (slot_q == 6'd63);
  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_FULL);
  assign pop         = frame_start & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign push        = asi_ss0_valid & (~full | pop);

  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + DW'(1);
    bclk_d    = bclk_q ^ wrap;
    slot_d    = slot_q;
    lrclk_d   = lrclk_q;
    sdata_d   = sdata_q;
    shift_d   = shift_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d   = level_q;
    ovf_d     = (asi_ss0_valid & full & ~pop) | (ovf_q & ~i_clear_flags);
    udf_d     = (frame_start & empty) | (udf_q & ~i_clear_flags);

    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase

    if (fall) begin
      slot_d  = slot_nxt;
      lrclk_d = slot_nxt[5];
      sdata_d = 1'b0;
      if (frame_start) begin
        shift_d = pop ? mem_q[rd_ptr_q] : '0;
      end else if (slot_nxt[4:0] >= 5'd1 && slot_nxt[4:0] <= 5'd24) begin
        // Rotating keeps the sample intact for the right channel after 24 bits.
        sdata_d = shift_q[23];
        shift_d = {shift_q[22:0], shift_q[23]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
      sdata_q   <= 1'b0;
      slot_q    <= 6'd63;
      shift_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      sdata_q   <= sdata_d;
      slot_q    <= slot_d;
      shift_q   <= shift_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= asi_ss0_data[23:0];
  end

  assign o_bclk       = bclk_q;
  assign o_lrclk      = lrclk_q;
  assign o_sdata      = sdata_q;
  assign o_overflow   = ovf_q;
  assign o_underflow  = udf_q;
  assign o_fifo_level = level_q;
endmodule

// File: tb/tb_i2s_sample_serializer.sv
// Directed bench for i2s_sample_serializer: a negedge monitor captures each
// I2S frame by slot and the test compares frames and flags to hand values.
module tb_i2s_sample_serializer;
  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int LW         = $clog2(FIFO_DEPTH) + 1;
  localparam int FRAME_CYC  = 128 * CLK_DIV;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   data = '0;
  logic          valid = 1'b0;
  logic          clr = 1'b0;
  logic          o_bclk, o_lrclk, o_sdata, o_overflow, o_underflow;
  logic [LW-1:0] o_fifo_level;

  always #5 clk = ~clk;

  i2s_sample_serializer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .asi_ss0_data(data), .asi_ss0_valid(valid), .i_clear_flags(clr),
    .o_bclk(o_bclk), .o_lrclk(o_lrclk), .o_sdata(o_sdata),
    .o_overflow(o_overflow), .o_underflow(o_underflow),
    .o_fifo_level(o_fifo_level)
  );

  int checks = 0;
  int failures = 0;

  // Frame monitor: tracks the slot independently from BCLK falling edges.
  bit         prev_bclk = 1'b0;
  logic [5:0] mon_slot = 6'd63;
  logic [5:0] mon_slot_n;
  int         frame_cnt = 0;
  logic       cap_lr [64];
  logic       cap_sd [64];

  assign mon_slot_n = mon_slot + 6'd1;

  always @(negedge clk) begin
    prev_bclk <= o_bclk;
    if (reset) begin
      mon_slot <= 6'd63;
    end else if (prev_bclk && !o_bclk) begin
      mon_slot <= mon_slot_n;
      cap_lr[mon_slot_n] <= o_lrclk;
      cap_sd[mon_slot_n] <= o_sdata;
      if (mon_slot_n == 6'd63) frame_cnt <= frame_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] din;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_frame();
    int  start;
    bit  done;
    start = frame_cnt;
    done  = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      @(posedge clk); #1;
      if (frame_cnt != start) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("wait_frame_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_frame(input string name, input logic [23:0] exp);
    logic [23:0] l, r;
    logic        oth;
    logic [63:0] lr;
    l = '0; r = '0; oth = 1'b0; lr = '0;
    for (int s = 0; s < 64; s++) begin
      lr[s] = cap_lr[s];
      if (s >= 1 && s <= 24)       l[24 - s] = cap_sd[s];
      else if (s >= 33 && s <= 56) r[56 - s] = cap_sd[s];
      else                         oth = oth | cap_sd[s];
    end
    chk({name, "_left"},  64'(l),   64'(exp));
    chk({name, "_right"}, 64'(r),   64'(exp));
    chk({name, "_idle"},  64'(oth), 64'd0);
    chk({name, "_lrclk"}, lr,       64'hFFFF_FFFF_0000_0000);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk); reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      data  = first + 32'(i);
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    chk("clear_ovf", 64'(o_overflow), 64'd0);
    chk("clear_udf", 64'(o_underflow), 64'd0);
    @(negedge clk); clr = 1'b0;
  endtask

  // Drives valid so that it is sampled on the very edge that enters slot 0.
  task automatic arm_at_slot0(input logic [31:0] d);
    int hi;
    bit done;
    hi = 0;
    done = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      @(negedge clk);
      hi = o_bclk ? hi + 1 : 0;
      if (mon_slot == 6'd63 && hi == CLK_DIV) begin
        data  = d;
        valid = 1'b1;
        done  = 1'b1;
        break;
      end
    end
    if (!done) chk("arm_slot0_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_slot(input logic [5:0] s);
    bit done;
    done = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      @(negedge clk);
      if (mon_slot == s) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("wait_slot_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int rise, fall;

    vecs[0] = '{din: 32'hFF80_0001, exp: 24'h800001};
    vecs[1] = '{din: 32'h127F_FFFF, exp: 24'h7FFFFF};
    vecs[2] = '{din: 32'h00FF_FFFF, exp: 24'hFFFFFF};
    vecs[3] = '{din: 32'h5555_5555, exp: 24'h555555};
    vecs[4] = '{din: 32'hDEAD_BEEF, exp: 24'hADBEEF};

    // Reset values and first BCLK edges
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_bclk",  64'(o_bclk),       64'd0);
    chk("rst_lrclk", 64'(o_lrclk),      64'd0);
    chk("rst_sdata", 64'(o_sdata),      64'd0);
    chk("rst_ovf",   64'(o_overflow),   64'd0);
    chk("rst_udf",   64'(o_underflow),  64'd0);
    chk("rst_level", 64'(o_fifo_level), 64'd0);
    @(negedge clk); reset = 1'b0;
    rise = 0; fall = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rise == 0 && o_bclk) rise = c;
      else if (rise != 0 && fall == 0 && !o_bclk) fall = c;
    end
    chk("first_bclk_rise", 64'(rise), 64'd2);
    chk("first_bclk_fall", 64'(fall), 64'd4);

    // Single sample pushed before the first frame start
    apply_reset(5);
    data = 32'h00A5_C3F1; valid = 1'b1;
    @(posedge clk); #1;
    chk("push_level_latency", 64'(o_fifo_level), 64'd1);
    @(negedge clk); valid = 1'b0;
    wait_frame();
    check_frame("single", 24'hA5C3F1);
    chk("single_udf", 64'(o_underflow), 64'd0);
    chk("single_ovf", 64'(o_overflow),  64'd0);

    // Underflow for three empty frames, clear, then a sample keeps it clear
    wait_frame();
    check_frame("udf_frame1", 24'h0);
    chk("udf_set", 64'(o_underflow), 64'd1);
    wait_frame();
    check_frame("udf_frame2", 24'h0);
    wait_frame();
    check_frame("udf_frame3", 24'h0);
    wait_cycles(20);
    pulse_clear();
    push_seq(32'h0012_3456, 1);
    wait_frame();
    chk("udf_stays_clear_a", 64'(o_underflow), 64'd0);
    wait_frame();
    check_frame("after_udf", 24'h123456);
    chk("udf_stays_clear_b", 64'(o_underflow), 64'd0);

    // Table of samples, each pushed mid-frame and carried by the next frame
    for (int v = 0; v < 5; v++) begin
      wait_cycles(20);
      push_seq(vecs[v].din, 1);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_level", v), 64'(o_fifo_level), 64'd1);
      wait_frame();
      wait_frame();
      check_frame($sformatf("vec%0d", v), vecs[v].exp);
    end

    // Overflow: ten pushes in one frame, only eight survive in order
    wait_cycles(20);
    pulse_clear();
    push_seq(32'd1, 10);
    @(posedge clk); #1;
    chk("ovf_level", 64'(o_fifo_level), 64'd8);
    chk("ovf_flag",  64'(o_overflow),   64'd1);
    wait_frame();
    for (int k = 1; k <= 8; k++) begin
      wait_frame();
      check_frame($sformatf("ovf_order%0d", k), 24'(k));
    end
    wait_frame();
    check_frame("ovf_dropped", 24'h0);

    // Push on the pop edge with the FIFO full
    wait_cycles(20);
    pulse_clear();
    push_seq(32'h11, 8);
    @(posedge clk); #1;
    chk("full_level", 64'(o_fifo_level), 64'd8);
    arm_at_slot0(32'h19);
    @(posedge clk); #1;
    chk("full_pop_push_level", 64'(o_fifo_level), 64'd8);
    chk("full_pop_push_ovf",   64'(o_overflow),   64'd0);
    @(negedge clk); valid = 1'b0;
    wait_frame();
    check_frame("full_head", 24'h11);

    // Push on the pop edge with the FIFO empty
    apply_reset(3);
    arm_at_slot0(32'h0033_CC0F);
    @(posedge clk); #1;
    chk("empty_pop_push_level", 64'(o_fifo_level), 64'd1);
    chk("empty_pop_push_udf",   64'(o_underflow),  64'd1);
    @(negedge clk); valid = 1'b0;
    wait_frame();
    check_frame("empty_frame0", 24'h0);
    wait_frame();
    check_frame("empty_frame1", 24'h33CC0F);

    // Mid-frame reset with three samples queued
    wait_cycles(20);
    push_seq(32'h0000_0777, 3);
    @(posedge clk); #1;
    chk("mid_level_before", 64'(o_fifo_level), 64'd3);
    wait_slot(6'd40);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_bclk",  64'(o_bclk),       64'd0);
    chk("mid_rst_lrclk", 64'(o_lrclk),      64'd0);
    chk("mid_rst_sdata", 64'(o_sdata),      64'd0);
    chk("mid_rst_ovf",   64'(o_overflow),   64'd0);
    chk("mid_rst_udf",   64'(o_underflow),  64'd0);
    chk("mid_rst_level", 64'(o_fifo_level), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    wait_frame();
    check_frame("mid_after", 24'h0);
    chk("mid_after_udf",   64'(o_underflow),  64'd1);
    chk("mid_after_level", 64'(o_fifo_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2s_sample_serializer.md
# i2s_sample_serializer

Downstream stage of `synthesizer_top_p`. It sinks the Avalon-ST mono sample stream (`aso_ss0_data`/`aso_ss0_valid`) into a small FIFO and serializes each sample as a 24-bit stereo I2S frame to the external audio codec. The same sample is sent on both channels. Overflow and underflow are reported through sticky flags, because the source has no backpressure.

## Interface
- `CLK_DIV`, default 8: `clk` cycles per half BCLK period; must be ≥2.
- `FIFO_DEPTH`, default 8: sample FIFO entries; power of two.
- `clk`, in, 1: system clock; the only clock.
- `reset`, in, 1: synchronous, active-high reset.
- `asi_ss0_data`, in, 32: sample word; `[23:0]` is a signed 24-bit sample; `[31:24]` is ignored.
- `asi_ss0_valid`, in, 1: qualifies `asi_ss0_data` for one cycle; there is no ready signal.
- `i_clear_flags`, in, 1: one-cycle pulse that clears both sticky flags.
- `o_bclk`, out, 1: I2S bit clock.
- `o_lrclk`, out, 1: word select; 0 = left, 1 = right.
- `o_sdata`, out, 1: serial data, MSB first.
- `o_overflow`, out, 1: sticky flag; a write arrived while the FIFO was full.
- `o_underflow`, out, 1: sticky flag; a frame started while the FIFO was empty.
- `o_fifo_level`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Reset** (synchronous, active-high):
  - FIFO empty, `o_fifo_level`=0.
  - `div_cnt`=0, `slot`=63.
  - `o_bclk`=0, `o_lrclk`=0, `o_sdata`=0, both flags 0, shift register 0.
  - Reset asserted mid-frame aborts the frame immediately; the FIFO contents are discarded.
- **FIFO write**: on every cycle with `asi_ss0_valid`=1:
  - If not full, store `[23:0]`.
  - If full, drop the word and set `o_overflow`.
- **BCLK generation**:
  - `div_cnt` counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps to 0 and `o_bclk` toggles.
  - A toggle from 1 to 0 is a falling event F.
- **Slot counter**: at each F, `slot` advances modulo 64, so a frame is 64 BCLK periods. Each channel occupies 32 slots.
- **At F entering slot 0**:
  - If the FIFO is non-empty, pop the head into the 24-bit shift register.
  - If it is empty, load 0 and set `o_underflow`.
  - The pop decision uses the FIFO state before this cycle. A push in the same cycle is stored normally.
  - Push and pop in the same cycle while the FIFO is full is legal: no overflow, level unchanged.
- **Outputs, updated only at F**:
  - `o_lrclk` = (slot ≥ 32).
  - `o_sdata` = sample[24-slot] for slot 1..24.
  - `o_sdata` = sample[56-slot] for slot 33..56.
  - `o_sdata` = 0 otherwise.
  - This is standard I2S: the MSB goes out one BCLK after the LRCLK edge. The same held sample is used for both channels.
- **`i_clear_flags`**: clears both flags. If a set condition occurs in the same cycle, the set wins.
- **Ordering**: samples are never reordered or duplicated. Each popped sample is transmitted in exactly one frame.

## Timing
- BCLK period = 2·CLK_DIV `clk` cycles. Frame = 128·CLK_DIV cycles.
- Example: 50 MHz `clk` with CLK_DIV=8 gives a 48.83 kHz frame rate.
- After reset deassert:
  - First rising BCLK edge at cycle CLK_DIV.
  - First F at cycle 2·CLK_DIV. This is slot 0, and the first pop happens here.
- Output registers change in the same cycle that `o_bclk` goes 0, so data is stable at every rising edge. The codec samples on rising BCLK.
- Write-to-level latency is 1 cycle: `o_fifo_level` reflects a push on the next cycle.
- Pop latency: the sample MSB appears on `o_sdata` at the next F after the pop, i.e. 2·CLK_DIV cycles later.
- The flags assert on the cycle after the triggering event.

## Test plan
All scenarios use CLK_DIV=2 and FIFO_DEPTH=8.
- **Reset values**: hold reset for 5 cycles, then check all outputs are 0 and `o_fifo_level`=0. Check the first `o_bclk` rise occurs 2 cycles after deassert and the first fall 4 cycles after.
- **Single sample**: push 0x00A5_C3F1 before the first F. Left slots 1–24 must serialize 0xA5C3F1 MSB first; right slots 33–56 must repeat it. All other slots are 0. `o_lrclk` is 0 for slots 0–31 and 1 for slots 32–63.
- **Underflow**: no pushes for 3 frames.
  - `o_sdata` stays 0 and `o_underflow`=1 after the first F.
  - Pulse `i_clear_flags` and check the flag drops.
  - Push one sample and check the flag stays 0 for the next frame.
- **Overflow**: push 10 consecutive samples 1..10 within one frame. `o_overflow`=1 and `o_fifo_level` saturates at 8. The next frames carry samples 1..8 in order; 9 and 10 are lost.
- **Corner cases**:
  - Push on the exact slot-0 pop cycle with the FIFO full: no overflow, level remains 8.
  - Same push with the FIFO empty: underflow set, level becomes 1.
- **Mid-frame reset**: assert reset at slot 40 with 3 samples queued. All outputs return to reset values and the level is 0. The next frame is 0 with underflow set.
